instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the multicycle MIPS core. Fetches 32-bit instruction words from the instruction-cache port and buffers them in a 2-entry prefetch FIFO. Presents them, with their PC, to the decode/control stage through a valid/ready handshake. Accepts branch/jump redirects from the datapath, flushes stale words and restarts fetching at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ICACHE_ren`  out  1  read request to instruction cache
- `ICACHE_addr`  out  30  word address (PC[31:2]) of the request
- `ICACHE_rdata`  in  32  instruction word, valid in a cycle with `ICACHE_ren`=1 and `ICACHE_stall`=0
- `ICACHE_stall`  in  1  cache busy; request not complete this cycle
- `inst_valid`  out  1  FIFO head holds a valid instruction
- `inst`  out  32  FIFO head instruction word (0 when empty)
- `inst_pc`  out  32  PC of `inst` (0 when empty)
- `inst_ready`  in  1  decode accepts head this cycle
- `redirect`  in  1  one-cycle pulse: discard buffered or in-flight words, fetch from `redirect_pc`
- `redirect_pc`  in  32  new fetch address, bits [1:0] ignored (treated as 0)

## Operation
- Registers: `fetch_pc` (32), 2-entry FIFO of {inst, pc}, `count` (0..2), FSM state, `target_pc` (32).
- Request completes at an edge where `ICACHE_ren`=1 and `ICACHE_stall`=0. Push = completion in FETCH. Pop = `inst_valid` & `inst_ready`.
- `count_next` = count + push − pop. There is at most one outstanding request, so a push never finds the FIFO full.
- FSM states:
  - IDLE: `ICACHE_ren`=0. Goes to FETCH when `count_next` < 2.
  - FETCH: `ICACHE_ren`=1, `ICACHE_addr`=`fetch_pc`[31:2]. On completion, push {`ICACHE_rdata`, `fetch_pc`} and set `fetch_pc` += 4. Stays in FETCH if `count_next` < 2, otherwise goes to IDLE.
  - DRAIN: `ICACHE_ren`=1 with the old address held. On completion, discard the data, set `fetch_pc` ← `target_pc` and go to FETCH.
- Once `ICACHE_ren` is asserted, the block holds `ICACHE_ren` and `ICACHE_addr` stable until completion. It never withdraws a request while `ICACHE_stall`=1.
- `redirect` (highest priority, overrides push and pop at the same edge):
  - The FIFO is cleared (`count` ← 0).
  - In IDLE, or in FETCH with `ICACHE_stall`=0: `fetch_pc` ← `redirect_pc`; any completing word is discarded; next state is FETCH.
  - In FETCH with `ICACHE_stall`=1: `target_pc` ← `redirect_pc`; next state is DRAIN.
  - In DRAIN: `target_pc` ← `redirect_pc` (latest wins); the FSM stays in DRAIN unless the request completes that edge, in which case it applies the new target and goes to FETCH.
- Pop with `redirect` at the same edge: the word is considered consumed; the block raises no error.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - state IDLE, `ICACHE_ren`=0, `ICACHE_addr`=`RESET_PC`[31:2], `fetch_pc`=`RESET_PC`.
  - `count`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `target_pc`=0.
- First edge after `rst` falls: IDLE→FETCH, so `ICACHE_ren`=1 in the first cycle after release.
- Latency: a word completing at edge N drives `inst_valid`=1 in cycle N+1 if the FIFO was empty.
- Throughput: with zero stall and `inst_ready`=1, one instruction per cycle.
- Stall of k cycles delays completion by k cycles.
- Decode held off (`inst_ready`=0): 2 words are buffered, then the FSM goes IDLE with `ICACHE_ren`=0. On the next pop it re-enters FETCH one cycle later.
- Redirect at edge N, with no request in flight at N: `ICACHE_ren`=1 with the new address in cycle N+1, and `inst_valid`=0 in cycle N+1.
- `rst` asserted mid-request: the request is abandoned and all state returns to its reset value immediately (asynchronous reset).

## Test plan
- Reset release, `RESET_PC`=0, stall=0, ready=1, cache returns word = 32'h2000_0000|addr → `ICACHE_addr` 0,1,2,… on consecutive cycles; `inst_pc` 0,4,8 one cycle later; `inst_valid` stays high.
- `inst_ready`=0 from reset → exactly 2 completions (PC 0,4), then `ICACHE_ren`=0. Raise ready → pops PC 0 then 4, fetch resumes at address 2 (PC 8).
- `ICACHE_stall`=1 for 3 cycles on address 5 → `ICACHE_ren`/`ICACHE_addr` stable for 4 cycles; `inst_pc`=20 appears the cycle after stall drops.
- `redirect` to 32'h100 while stalled on PC 8 → DRAIN holds address 2 until stall drops; the word for PC 8 is never presented; next request is address 32'h40; next `inst_pc`=32'h100.
- Two redirects during DRAIN (0x200, then 0x300) plus `redirect` coinciding with a pop and a full FIFO → FIFO empty next cycle; fetch resumes at 0x300 only.
- `RESET_PC`=32'hFFFF_FFF8 → `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert `rst` while stalled → `ICACHE_ren`=0 and `inst_valid`=0 immediately.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-cache request port plus decode-side instruction port.
// Handshakes: a cache request completes at a rising edge with ICACHE_ren=1 and ICACHE_stall=0, and the
// requester holds ren/addr stable until then; an instruction transfers at an edge with inst_valid=1 and inst_ready=1.
interface instr_fetch_if;
   logic        ICACHE_ren;
   logic [29:0] ICACHE_addr;
   logic [31:0] ICACHE_rdata;
   logic        ICACHE_stall;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output ICACHE_ren, ICACHE_addr, inst_valid, inst, inst_pc,
      input  ICACHE_rdata, ICACHE_stall, inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  ICACHE_ren, ICACHE_addr, inst_valid, inst, inst_pc,
      output ICACHE_rdata, ICACHE_stall, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: single-outstanding cache requests into a 2-entry prefetch FIFO,
// with redirect flush and a DRAIN state that absorbs a stalled stale request.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_if.master      bus,
   output logic [1:0]         o_state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_fetch_pc, w_fetch_pc_next;
   logic [31:0] r_target_pc, w_target_pc_next;
   logic [31:0] r_fifo_inst [2];
   logic [31:0] r_fifo_pc [2];
   logic        r_rd_ptr, r_wr_ptr;
   logic [1:0]  r_count, w_count_next;
   logic        w_ren, w_valid, w_complete, w_pop, w_push;
   logic [31:0] w_redirect_pc;

   assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
   assign w_ren         = (r_state != S_IDLE);
   assign w_valid       = (r_count != 2'd0);
   assign w_complete    = w_ren & ~bus.ICACHE_stall;
   assign w_pop         = w_valid & bus.inst_ready;

   always_comb begin
      w_state_next     = r_state;
      w_fetch_pc_next  = r_fetch_pc;
      w_target_pc_next = r_target_pc;
      w_push           = 1'b0;
      w_count_next     = r_count - {1'b0, w_pop};
      case (r_state)
         S_IDLE: begin
            if (bus.redirect) begin
               w_fetch_pc_next = w_redirect_pc;
               w_state_next    = S_FETCH;
            end else if (w_count_next < 2'd2) begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.redirect) begin
               // A stalled request cannot be withdrawn, so park the target until it completes.
               if (bus.ICACHE_stall) begin
                  w_target_pc_next = w_redirect_pc;
                  w_state_next     = S_DRAIN;
               end else begin
                  w_fetch_pc_next = w_redirect_pc;
               end
            end else if (w_complete) begin
               w_push          = 1'b1;
               w_fetch_pc_next = r_fetch_pc + 32'd4;
               w_count_next    = w_count_next + 2'd1;
               w_state_next    = (w_count_next < 2'd2) ? S_FETCH : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (bus.redirect) w_target_pc_next = w_redirect_pc;
            if (w_complete) begin
               w_fetch_pc_next = bus.redirect ? w_redirect_pc : r_target_pc;
               w_state_next    = S_FETCH;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (bus.redirect) w_count_next = 2'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_fetch_pc     <= RESET_PC;
         r_target_pc    <= 32'h0;
         r_count        <= 2'd0;
         r_rd_ptr       <= 1'b0;
         r_wr_ptr       <= 1'b0;
         r_fifo_inst[0] <= 32'h0;
         r_fifo_inst[1] <= 32'h0;
         r_fifo_pc[0]   <= 32'h0;
         r_fifo_pc[1]   <= 32'h0;
      end else begin
         r_state     <= w_state_next;
         r_fetch_pc  <= w_fetch_pc_next;
         r_target_pc <= w_target_pc_next;
         r_count     <= w_count_next;
         if (bus.redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
         end else begin
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            if (w_push) begin
               r_fifo_inst[r_wr_ptr] <= bus.ICACHE_rdata;
               r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
               r_wr_ptr              <= ~r_wr_ptr;
            end
         end
      end
   end

   assign bus.ICACHE_ren  = w_ren;
   assign bus.ICACHE_addr = r_fetch_pc[31:2];
   assign bus.inst_valid  = w_valid;
   assign bus.inst        = w_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
   assign bus.inst_pc     = w_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
   assign o_state         = r_state;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle-exact scenarios plus a randomized run checked
// against an in-order instruction-stream model (expected next PC, reset on every redirect).
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0] st0, st1;
   int total = 0;
   int bad = 0;

   instr_fetch_if if0();
   instr_fetch_if if1();

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'h2000_0000 | {2'b00, pc[31:2]};
   endfunction

   assign if0.ICACHE_rdata = word_of({if0.ICACHE_addr, 2'b00});
   assign if1.ICACHE_rdata = word_of({if1.ICACHE_addr, 2'b00});

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst), .bus(if0), .o_state(st0));
   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst), .bus(if1), .o_state(st1));

   always #5 clk = ~clk;

   task automatic do_reset;
      rst = 1'b1;
      if0.ICACHE_stall = 1'b0;
      if0.inst_ready   = 1'b1;
      if0.redirect     = 1'b0;
      if0.redirect_pc  = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      if0.ICACHE_stall = 1'b0; if0.inst_ready = 1'b1; if0.redirect = 1'b0; if0.redirect_pc = 32'h0;
      @(negedge clk);
      total++; if (if0.ICACHE_ren !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0h exp=0", if0.ICACHE_ren); end
      total++; if (if0.ICACHE_addr !== 30'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", if0.ICACHE_addr); end
      total++; if (if0.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", if0.inst_valid); end
      total++; if (if0.inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%0h exp=0", if0.inst); end
      total++; if (if0.inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", if0.inst_pc); end
      total++; if (if1.ICACHE_addr !== 30'h3FFF_FFFE) begin bad++; $display("FAIL reset_addr1 got=%0h exp=3ffffffe", if1.ICACHE_addr); end
   endtask

   task automatic test_stream;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         total++; if (if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'(k - 1)) begin
            bad++; $display("FAIL stream_addr k=%0d got ren=%0h addr=%0h exp ren=1 addr=%0h", k, if0.ICACHE_ren, if0.ICACHE_addr, k - 1);
         end
         if (k >= 2) begin
            total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'(4 * (k - 2)) || if0.inst !== word_of(32'(4 * (k - 2)))) begin
               bad++; $display("FAIL stream_inst k=%0d got v=%0h pc=%0h inst=%0h exp pc=%0h", k, if0.inst_valid, if0.inst_pc, if0.inst, 4 * (k - 2));
            end
         end
      end
   endtask

   task automatic test_ready_low;
      int comps;
      comps = 0;
      do_reset();
      if0.inst_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (if0.ICACHE_ren && !if0.ICACHE_stall) comps++;
      end
      total++; if (comps != 2) begin bad++; $display("FAIL hold_completions got=%0d exp=2", comps); end
      total++; if (if0.ICACHE_ren !== 1'b0) begin bad++; $display("FAIL hold_ren got=%0h exp=0", if0.ICACHE_ren); end
      total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'h0) begin bad++; $display("FAIL hold_head got v=%0h pc=%0h exp v=1 pc=0", if0.inst_valid, if0.inst_pc); end
      if0.inst_ready = 1'b1;
      @(negedge clk);
      total++; if (if0.inst_pc !== 32'h4 || if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'h2) begin
         bad++; $display("FAIL resume1 got pc=%0h ren=%0h addr=%0h exp pc=4 ren=1 addr=2", if0.inst_pc, if0.ICACHE_ren, if0.ICACHE_addr);
      end
      @(negedge clk);
      total++; if (if0.inst_pc !== 32'h8 || if0.ICACHE_addr !== 30'h3) begin
         bad++; $display("FAIL resume2 got pc=%0h addr=%0h exp pc=8 addr=3", if0.inst_pc, if0.ICACHE_addr);
      end
   endtask

   task automatic test_stall;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k >= 6 && k <= 9) begin
            total++; if (if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'h5) begin
               bad++; $display("FAIL stall_hold k=%0d got ren=%0h addr=%0h exp ren=1 addr=5", k, if0.ICACHE_ren, if0.ICACHE_addr);
            end
         end
         if (k == 7) begin
            total++; if (if0.inst_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%0h exp=0", if0.inst_valid); end
         end
         if (k == 10) begin
            total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'd20) begin
               bad++; $display("FAIL stall_pc got v=%0h pc=%0h exp v=1 pc=14", if0.inst_valid, if0.inst_pc);
            end
         end
         if (k == 6) if0.ICACHE_stall = 1'b1;
         if (k == 9) if0.ICACHE_stall = 1'b0;
      end
   endtask

   task automatic test_redirect_drain;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k >= 4 && k <= 6) begin
            total++; if (if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'h2 || if0.inst_valid !== 1'b0) begin
               bad++; $display("FAIL drain_hold k=%0d got ren=%0h addr=%0h v=%0h exp ren=1 addr=2 v=0", k, if0.ICACHE_ren, if0.ICACHE_addr, if0.inst_valid);
            end
         end
         if (k == 7) begin
            total++; if (if0.ICACHE_addr !== 30'h40 || if0.inst_valid !== 1'b0) begin
               bad++; $display("FAIL drain_target got addr=%0h v=%0h exp addr=40 v=0", if0.ICACHE_addr, if0.inst_valid);
            end
         end
         if (k == 8) begin
            total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'h100 || if0.inst !== 32'h2000_0040) begin
               bad++; $display("FAIL drain_inst got v=%0h pc=%0h inst=%0h exp pc=100 inst=20000040", if0.inst_valid, if0.inst_pc, if0.inst);
            end
         end
         if (k == 3) if0.ICACHE_stall = 1'b1;
         if (k == 4) begin if0.redirect = 1'b1; if0.redirect_pc = 32'h100; end
         if (k == 5) if0.redirect = 1'b0;
         if (k == 6) if0.ICACHE_stall = 1'b0;
      end
   endtask

   task automatic test_double_redirect;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 5 || k == 6) begin
            total++; if (if0.ICACHE_addr !== 30'h2 || if0.inst_valid !== 1'b0) begin
               bad++; $display("FAIL dbl_hold k=%0d got addr=%0h v=%0h exp addr=2 v=0", k, if0.ICACHE_addr, if0.inst_valid);
            end
         end
         if (k == 7) begin
            total++; if (if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'hC0 || if0.inst_valid !== 1'b0) begin
               bad++; $display("FAIL dbl_target got ren=%0h addr=%0h v=%0h exp ren=1 addr=c0 v=0", if0.ICACHE_ren, if0.ICACHE_addr, if0.inst_valid);
            end
         end
         if (k == 8) begin
            total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'h300) begin
               bad++; $display("FAIL dbl_inst got v=%0h pc=%0h exp v=1 pc=300", if0.inst_valid, if0.inst_pc);
            end
         end
         if (k == 3) if0.ICACHE_stall = 1'b1;
         if (k == 4) begin if0.redirect = 1'b1; if0.redirect_pc = 32'h200; end
         if (k == 5) if0.redirect_pc = 32'h300;
         if (k == 6) begin if0.redirect = 1'b0; if0.ICACHE_stall = 1'b0; end
      end
      // Redirect coinciding with a pop while the FIFO is full.
      do_reset();
      if0.inst_ready = 1'b0;
      repeat (4) @(negedge clk);
      total++; if (if0.inst_valid !== 1'b1 || if0.ICACHE_ren !== 1'b0) begin
         bad++; $display("FAIL full_pre got v=%0h ren=%0h exp v=1 ren=0", if0.inst_valid, if0.ICACHE_ren);
      end
      if0.inst_ready = 1'b1; if0.redirect = 1'b1; if0.redirect_pc = 32'h303;
      @(negedge clk);
      if0.redirect = 1'b0;
      total++; if (if0.inst_valid !== 1'b0 || if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== 30'hC0) begin
         bad++; $display("FAIL full_flush got v=%0h ren=%0h addr=%0h exp v=0 ren=1 addr=c0", if0.inst_valid, if0.ICACHE_ren, if0.ICACHE_addr);
      end
      @(negedge clk);
      total++; if (if0.inst_valid !== 1'b1 || if0.inst_pc !== 32'h300) begin
         bad++; $display("FAIL full_resume got v=%0h pc=%0h exp v=1 pc=300", if0.inst_valid, if0.inst_pc);
      end
   endtask

   task automatic test_wrap_and_async_reset;
      logic [31:0] exp_pc;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            total++; if (if1.ICACHE_addr !== 30'h3FFF_FFFE) begin bad++; $display("FAIL wrap_addr got=%0h exp=3ffffffe", if1.ICACHE_addr); end
         end
         if (k >= 2 && k <= 4) begin
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
            total++; if (if1.inst_valid !== 1'b1 || if1.inst_pc !== exp_pc || if1.inst !== word_of(exp_pc)) begin
               bad++; $display("FAIL wrap_pc k=%0d got v=%0h pc=%0h inst=%0h exp pc=%0h", k, if1.inst_valid, if1.inst_pc, if1.inst, exp_pc);
            end
         end
         if (k == 5) if0.ICACHE_stall = 1'b1;
      end
      total++; if (if0.ICACHE_ren !== 1'b1 || if1.inst_valid !== 1'b1) begin
         bad++; $display("FAIL pre_rst got ren0=%0h v1=%0h exp 1 1", if0.ICACHE_ren, if1.inst_valid);
      end
      #2 rst = 1'b1;
      #1;
      total++; if (if0.ICACHE_ren !== 1'b0 || if0.inst_valid !== 1'b0) begin
         bad++; $display("FAIL async_rst0 got ren=%0h v=%0h exp 0 0", if0.ICACHE_ren, if0.inst_valid);
      end
      total++; if (if1.ICACHE_ren !== 1'b0 || if1.inst_valid !== 1'b0) begin
         bad++; $display("FAIL async_rst1 got ren=%0h v=%0h exp 0 0", if1.ICACHE_ren, if1.inst_valid);
      end
      @(negedge clk);
      if0.ICACHE_stall = 1'b0;
   endtask

   task automatic test_random;
      logic [31:0] exp_pc;
      logic [29:0] prev_addr;
      logic        prev_hold, prev_redirect;
      int          pops;
      do_reset();
      exp_pc = 32'h0; prev_hold = 1'b0; prev_redirect = 1'b0; prev_addr = 30'h0; pops = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (prev_hold) begin
            total++; if (if0.ICACHE_ren !== 1'b1 || if0.ICACHE_addr !== prev_addr) begin
               bad++; $display("FAIL rnd_hold c=%0d got ren=%0h addr=%0h exp ren=1 addr=%0h", c, if0.ICACHE_ren, if0.ICACHE_addr, prev_addr);
            end
         end
         if (prev_redirect) begin
            total++; if (if0.inst_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush c=%0d got v=%0h exp=0", c, if0.inst_valid); end
         end
         if (if0.inst_valid === 1'b0) begin
            total++; if (if0.inst !== 32'h0 || if0.inst_pc !== 32'h0) begin
               bad++; $display("FAIL rnd_empty c=%0d got inst=%0h pc=%0h exp 0 0", c, if0.inst, if0.inst_pc);
            end
         end
         if0.ICACHE_stall = ($urandom_range(0, 9) < 3);
         if0.inst_ready   = ($urandom_range(0, 9) < 6);
         if0.redirect     = ($urandom_range(0, 19) == 0);
         if0.redirect_pc  = $urandom;
         if (if0.inst_valid === 1'b1 && if0.inst_ready) begin
            total++; if (if0.inst_pc !== exp_pc || if0.inst !== word_of(exp_pc)) begin
               bad++; $display("FAIL rnd_pop c=%0d got pc=%0h inst=%0h exp pc=%0h inst=%0h", c, if0.inst_pc, if0.inst, exp_pc, word_of(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         if (if0.redirect) exp_pc = if0.redirect_pc & 32'hFFFF_FFFC;
         prev_hold     = if0.ICACHE_ren & if0.ICACHE_stall;
         prev_addr     = if0.ICACHE_addr;
         prev_redirect = if0.redirect;
      end
      @(negedge clk);
      if0.ICACHE_stall = 1'b0; if0.redirect = 1'b0; if0.inst_ready = 1'b1;
      total++; if (pops < 300) begin bad++; $display("FAIL rnd_progress got=%0d exp>=300", pops); end
   endtask

   initial begin
      if1.ICACHE_stall = 1'b0;
      if1.inst_ready   = 1'b1;
      if1.redirect     = 1'b0;
      if1.redirect_pc  = 32'h0;
      test_reset();
      test_stream();
      test_ready_low();
      test_stall();
      test_redirect_drain();
      test_double_redirect();
      test_wrap_and_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
